// File: rtl/playback_pkg.sv
// Shared definitions for the playback sequencer.
// Holds the FSM state encoding and the default address/sample widths so the
// top level and any companion blocks agree on them.
package playback_pkg;

  localparam int ADDR_W_DEF = 9;
  localparam int DATA_W_DEF = 16;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_PLAY    = 3'd3,
    ST_LAST    = 3'd4
  } state_t;

endpackage

// File: rtl/edge_detect_rise.sv
// Rising-edge detector: one flop plus an AND gate.
// Ports:
//   clk  - clock
//   rst  - asynchronous active-low reset
//   din  - level input to watch
//   rise - high for the cycle in which din is 1 and was 0 on the previous edge
module edge_detect_rise (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise
);

  logic din_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      din_q <= 1'b0;
    end else begin
      din_q <= din;
    end
  end

  assign rise = din & ~din_q;

endmodule

// File: rtl/playback_sequencer.sv
// Sample playback sequencer: walks a sample RAM from address 0 to a latched
// end address, prefetching one sample ahead and handing it to the I2S output
// word on each frame-complete (done) rising edge. Optionally loops.
// Ports:
//   clk, rst          - clock, asynchronous active-low reset
//   start, stop       - level controls; stop has priority over everything
//   loop_en           - wrap to 0 (1) or finish (0) after end_adr, read live
//   end_adr           - last sample address (inclusive), latched on start
//   done              - I2S frame complete; only its rising edge matters
//   mem_data/mem_adr  - sample RAM read port (registered read, 1-cycle latency)
//   spkr_data         - I2S output word
//   busy              - high whenever not idle
//   underrun          - one-cycle pulse when a done edge arrives before the
//                       next sample has been prefetched
module playback_sequencer
  import playback_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              loop_en,
  input  logic [ADDR_W-1:0] end_adr,
  input  logic              done,
  input  logic [DATA_W-1:0] mem_data,
  output logic [ADDR_W-1:0] mem_adr,
  output logic [DATA_W-1:0] spkr_data,
  output logic              busy,
  output logic              underrun
);

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] mem_adr_reg, mem_adr_next;
  logic [ADDR_W-1:0] end_reg, end_next;
  logic [DATA_W-1:0] spkr_reg, spkr_next;
  logic [DATA_W-1:0] sample_reg, sample_next;
  logic              done_edge;

  edge_detect_rise u_done_edge (
    .clk  (clk),
    .rst  (rst),
    .din  (done),
    .rise (done_edge)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_adr_reg <= '0;
      end_reg     <= '0;
      spkr_reg    <= '0;
      sample_reg  <= '0;
    end else begin
      mem_adr_reg <= mem_adr_next;
      end_reg     <= end_next;
      spkr_reg    <= spkr_next;
      sample_reg  <= sample_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    mem_adr_next = mem_adr_reg;
    end_next     = end_reg;
    spkr_next    = spkr_reg;
    sample_next  = sample_reg;
    underrun     = 1'b0;

    if (stop) begin
      state_next   = ST_IDLE;
      mem_adr_next = '0;
      spkr_next    = '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            end_next     = end_adr;
            mem_adr_next = '0;
            state_next   = ST_FETCH;
          end
        end
        // RAM read is in flight; a frame ending now has nothing new to play.
        ST_FETCH: begin
          underrun   = done_edge;
          state_next = ST_CAPTURE;
        end
        ST_CAPTURE: begin
          underrun    = done_edge;
          sample_next = mem_data;
          state_next  = ST_PLAY;
        end
        ST_PLAY: begin
          if (done_edge) begin
            spkr_next = sample_reg;
            if (mem_adr_reg < end_reg) begin
              mem_adr_next = mem_adr_reg + ADDR_W'(1);
              state_next   = ST_FETCH;
            end else if (loop_en) begin
              mem_adr_next = '0;
              state_next   = ST_FETCH;
            end else begin
              state_next = ST_LAST;
            end
          end
        end
        // Final sample is on the output; the next frame edge silences it.
        ST_LAST: begin
          if (done_edge) begin
            spkr_next    = '0;
            mem_adr_next = '0;
            state_next   = ST_IDLE;
          end
        end
        default: begin
          state_next = ST_IDLE;
        end
      endcase
    end
  end

  assign mem_adr   = mem_adr_reg;
  assign spkr_data = spkr_reg;
  assign busy      = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_playback_sequencer.sv
// Directed bench for playback_sequencer with a registered-read sample RAM
// model holding RAM[i] = 16'h1000 + i.
module tb_playback_sequencer;

  localparam int ADDR_W = 9;
  localparam int DATA_W = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              stop = 1'b0;
  logic              loop_en = 1'b0;
  logic              done = 1'b0;
  logic [ADDR_W-1:0] end_adr = '0;
  logic [DATA_W-1:0] mem_data;
  logic [ADDR_W-1:0] mem_adr;
  logic [DATA_W-1:0] spkr_data;
  logic              busy;
  logic              underrun;

  logic [DATA_W-1:0] ram [0:(1<<ADDR_W)-1];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  always @(posedge clk) mem_data <= ram[mem_adr];

  playback_sequencer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stop      (stop),
    .loop_en   (loop_en),
    .end_adr   (end_adr),
    .done      (done),
    .mem_data  (mem_data),
    .mem_adr   (mem_adr),
    .spkr_data (spkr_data),
    .busy      (busy),
    .underrun  (underrun)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept a start, check the address is presented one cycle later, then
  // step through FETCH and CAPTURE so the FSM sits in PLAY.
  task automatic begin_play(input logic [ADDR_W-1:0] e, input logic lp);
    start = 1'b1; end_adr = e; loop_en = lp;
    tick();
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || mem_adr !== '0) begin
      errors++;
      $display("FAIL start_latency: busy=%b mem_adr=%0d, required busy=1 mem_adr=0", busy, mem_adr);
    end
    tick();
    tick();
  endtask

  // One done pulse followed by enough idle cycles to prefetch the next sample.
  task automatic pulse();
    done = 1'b1;
    tick();
    done = 1'b0;
    tick();
    tick();
    tick();
  endtask

  task automatic test_reset();
    #1 rst = 1'b0;
    #2;
    checks++;
    if (mem_adr !== '0 || spkr_data !== '0 || busy !== 1'b0 || underrun !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: mem_adr=%0d spkr=%h busy=%b underrun=%b, required all 0",
               mem_adr, spkr_data, busy, underrun);
    end
    tick();
    rst = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_idle: busy=%b, required 0", busy);
    end
  endtask

  task automatic test_one_shot();
    logic [DATA_W-1:0] exp;
    begin_play(9'd3, 1'b0);
    for (int i = 0; i < 4; i++) begin
      pulse();
      exp = 16'h1000 + DATA_W'(i);
      checks++;
      if (spkr_data !== exp || busy !== 1'b1) begin
        errors++;
        $display("FAIL one_shot[%0d]: spkr=%h busy=%b, required spkr=%h busy=1", i, spkr_data, busy, exp);
      end
    end
    pulse();
    checks++;
    if (spkr_data !== '0 || busy !== 1'b0 || mem_adr !== '0) begin
      errors++;
      $display("FAIL one_shot_end: spkr=%h busy=%b mem_adr=%0d, required 0000/0/0", spkr_data, busy, mem_adr);
    end
  endtask

  task automatic test_loop();
    logic [DATA_W-1:0] exp;
    begin_play(9'd1, 1'b1);
    for (int i = 0; i < 6; i++) begin
      pulse();
      exp = 16'h1000 + DATA_W'(i % 2);
      checks++;
      if (spkr_data !== exp || busy !== 1'b1) begin
        errors++;
        $display("FAIL loop[%0d]: spkr=%h busy=%b, required spkr=%h busy=1", i, spkr_data, busy, exp);
      end
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    checks++;
    if (busy !== 1'b0 || spkr_data !== '0) begin
      errors++;
      $display("FAIL loop_stop: busy=%b spkr=%h, required 0/0000", busy, spkr_data);
    end
  endtask

  task automatic test_stop_capture();
    start = 1'b1; end_adr = 9'd3; loop_en = 1'b0;
    tick();
    tick();
    tick();
    done = 1'b1;
    tick();
    done = 1'b0;
    // start is still held: it must not disturb the running playback.
    checks++;
    if (spkr_data !== 16'h1000 || mem_adr !== 9'd1) begin
      errors++;
      $display("FAIL start_while_busy: spkr=%h mem_adr=%0d, required 1000/1", spkr_data, mem_adr);
    end
    tick();
    stop = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b0 || spkr_data !== '0 || mem_adr !== '0) begin
      errors++;
      $display("FAIL stop_in_capture: busy=%b spkr=%h mem_adr=%0d, required 0/0000/0", busy, spkr_data, mem_adr);
    end
    stop = 1'b0;
    start = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL stop_release_idle: busy=%b, required 0", busy);
    end
  endtask

  task automatic test_underrun();
    start = 1'b1; end_adr = 9'd3; loop_en = 1'b0;
    tick();
    start = 1'b0;
    // FSM is in FETCH right after the start.
    done = 1'b1;
    @(negedge clk);
    checks++;
    if (underrun !== 1'b1 || mem_adr !== '0) begin
      errors++;
      $display("FAIL underrun_fetch: underrun=%b mem_adr=%0d, required 1/0", underrun, mem_adr);
    end
    tick();
    checks++;
    if (underrun !== 1'b0 || mem_adr !== '0) begin
      errors++;
      $display("FAIL underrun_one_cycle: underrun=%b mem_adr=%0d, required 0/0", underrun, mem_adr);
    end
    done = 1'b0;
    tick();
    // In PLAY now: transfer sample 0, then hit CAPTURE with another edge.
    done = 1'b1;
    tick();
    done = 1'b0;
    tick();
    done = 1'b1;
    @(negedge clk);
    checks++;
    if (underrun !== 1'b1) begin
      errors++;
      $display("FAIL underrun_capture: underrun=%b, required 1", underrun);
    end
    tick();
    checks++;
    if (spkr_data !== 16'h1000 || mem_adr !== 9'd1 || underrun !== 1'b0) begin
      errors++;
      $display("FAIL underrun_hold: spkr=%h mem_adr=%0d underrun=%b, required 1000/1/0",
               spkr_data, mem_adr, underrun);
    end
    done = 1'b0;
    tick();
    pulse();
    checks++;
    if (spkr_data !== 16'h1001) begin
      errors++;
      $display("FAIL underrun_recover: spkr=%h, required 1001", spkr_data);
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  task automatic test_reset_mid_play();
    begin_play(9'd3, 1'b0);
    pulse();
    pulse();
    pulse();
    checks++;
    if (spkr_data !== 16'h1002) begin
      errors++;
      $display("FAIL pre_reset_sample: spkr=%h, required 1002", spkr_data);
    end
    rst = 1'b0;
    #2;
    checks++;
    if (spkr_data !== '0 || busy !== 1'b0 || mem_adr !== '0) begin
      errors++;
      $display("FAIL async_reset: spkr=%h busy=%b mem_adr=%0d, required 0000/0/0", spkr_data, busy, mem_adr);
    end
    rst = 1'b1;
    pulse();
    pulse();
    checks++;
    if (busy !== 1'b0 || spkr_data !== '0) begin
      errors++;
      $display("FAIL reset_no_restart: busy=%b spkr=%h, required 0/0000", busy, spkr_data);
    end
  endtask

  task automatic test_single_sample();
    begin_play(9'd0, 1'b0);
    pulse();
    checks++;
    if (spkr_data !== 16'h1000 || busy !== 1'b1) begin
      errors++;
      $display("FAIL single_first: spkr=%h busy=%b, required 1000/1", spkr_data, busy);
    end
    pulse();
    checks++;
    if (spkr_data !== '0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL single_end: spkr=%h busy=%b, required 0000/0", spkr_data, busy);
    end
  endtask

  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++) begin
      ram[i] = 16'h1000 + DATA_W'(i);
    end
    test_reset();
    test_one_shot();
    test_loop();
    test_stop_capture();
    test_underrun();
    test_reset_mid_play();
    test_single_sample();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/playback_sequencer.md
PLAYBACK_SEQUENCER -- requirements
Module: playback_sequencer

Interface
REQ-001 Parameter ADDR_W, default 9, SHALL set the sample RAM address width.
REQ-002 Parameter DATA_W, default 16, SHALL set the sample width.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 start  input  1  SHALL request playback from address 0; level, sampled each cycle.
REQ-006 stop  input  1  SHALL abort playback; level, sampled each cycle.
REQ-007 loop_en  input  1  SHALL select wrap-to-0 (1) or halt (0) after end_adr.
REQ-008 end_adr  input  ADDR_W  SHALL give the last sample address, inclusive; sampled when start is accepted.
REQ-009 done  input  1  SHALL be the I2S frame-complete signal; only its rising edge is used.
REQ-010 mem_data  input  DATA_W  SHALL be the sample RAM read data, valid one cycle after mem_adr.
REQ-011 mem_adr  output  ADDR_W  SHALL drive the sample RAM read address.
REQ-012 spkr_data  output  DATA_W  SHALL drive the I2S output word, both channels.
REQ-013 busy  output  1  SHALL be high in every state except IDLE.
REQ-014 underrun  output  1  SHALL pulse for one cycle when a done edge finds no prefetched sample.

Function
REQ-015 States SHALL be IDLE, FETCH, CAPTURE, PLAY and LAST.
REQ-016 done_edge SHALL equal done AND NOT done_q, where done_q is done registered once.
REQ-017 In IDLE, start=1 and stop=0 SHALL latch end_adr, set mem_adr=0 and go to FETCH.
REQ-018 FETCH SHALL last exactly one cycle, then go to CAPTURE.
REQ-019 CAPTURE SHALL load mem_data into an internal next_sample register, then go to PLAY.
REQ-020 In PLAY, on done_edge, spkr_data SHALL load next_sample in that cycle.
REQ-021 If that transfer came from mem_adr < latched end_adr, mem_adr SHALL increment and the FSM SHALL go to FETCH.
REQ-022 If mem_adr = end_adr and loop_en=1, mem_adr SHALL wrap to 0 and the FSM SHALL go to FETCH.
REQ-023 If mem_adr = end_adr and loop_en=0, the FSM SHALL go to LAST.
REQ-024 In LAST, the next done_edge SHALL set spkr_data=0 and mem_adr=0 and go to IDLE.
REQ-025 A done_edge in FETCH or CAPTURE SHALL leave spkr_data unchanged, assert underrun for that cycle and not advance mem_adr.
REQ-026 stop=1 in any state SHALL force IDLE, spkr_data=0 and mem_adr=0 on the next edge; stop overrides start and done_edge.
REQ-027 start while busy SHALL be ignored.
REQ-028 loop_en SHALL be evaluated live at each end_adr transfer.
REQ-029 end_adr=0 SHALL play the single sample at address 0, repeated if loop_en=1.
REQ-030 Address arithmetic SHALL be unsigned ADDR_W bits with no carry out.
REQ-031 Latency from start to mem_adr presented SHALL be 1 cycle.
REQ-032 Latency from a done_edge in PLAY to spkr_data valid SHALL be 0 cycles (same-edge load).

Reset
REQ-033 On rst=0, the FSM SHALL go to IDLE and mem_adr, spkr_data, next_sample, end_adr latch, done_q, busy and underrun SHALL clear to 0, asynchronously.
REQ-034 Reset deassertion mid-playback SHALL resume in IDLE; no playback restarts without a new start.

Structure
REQ-035 The state encoding and the ADDR_W/DATA_W defaults SHALL live in a shared package, playback_pkg.
REQ-036 The done edge detector SHALL be one sub-module, edge_detect_rise (1 flop plus gate), reusable by the SPI side.

Verification
REQ-037 end_adr=3, loop_en=0, RAM[i]=16'h1000+i, four done pulses -> spkr_data 1000,1001,1002,1003; fifth pulse -> 0000, busy=0.
REQ-038 end_adr=1, loop_en=1, six done pulses -> spkr_data sequence 1000,1001,1000,1001,1000,1001, with busy held at 1.
REQ-039 stop asserted in the CAPTURE cycle, with start held high -> next cycle IDLE, spkr_data=0, mem_adr=0.
REQ-040 done rising in the cycle after a PLAY transfer (FSM in FETCH) -> underrun=1 for exactly 1 cycle, mem_adr unchanged.
REQ-041 rst pulsed low mid-PLAY while spkr_data=1002 -> spkr_data=0, busy=0 immediately; the FSM stays in IDLE until start.
REQ-042 end_adr=0, loop_en=0, one done pulse -> spkr_data=1000; second pulse -> 0000, busy=0.
